serial_mult_ctrl: RTL and testbench

Sequential unsigned multiplier that time-shares one 1-bit full-adder cell (sum = a^b^cin, carry = majority(a,b,cin)) across all partial-product additions. A controller FSM drives the cell bit-serially, one bit per clock, in shift-and-add order. It is the area-minimal alternative to a fully parallel 4x4 Wallace tree, and sits beside that tree as a drop-in multiplier with a start/done handshake.

---
 rtl/serial_mult_ctrl.sv | 108 ++++++++++
 tb/tb_serial_mult_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/serial_mult_ctrl.sv
// Bit-serial shift-and-add unsigned multiplier: one full-adder cell is reused for
// every partial-product bit, sequenced by a three-state controller.
module serial_mult_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  // Handshake: start is accepted only on an edge where the FSM is IDLE (a and b
  // are captured on that edge); start while busy is dropped. done is a one-cycle
  // pulse in IDLE that coincides with prod taking the new result, so a start held
  // during the done cycle launches the next operation with no gap.

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int AW = $clog2(2 * WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ADD, SHIFT} state_t;

  state_t               state, state_n;
  logic [WIDTH-1:0]     a_r, b_r;
  logic [2*WIDTH-1:0]   acc;
  logic                 cy;
  logic [CW-1:0]        bit_cnt, iter;

  logic                 op, fa_in, fa_sum, fa_cy;
  logic [AW-1:0]        hi_idx;
  logic [2*WIDTH-1:0]   acc_shift;

  // Single shared full-adder cell working on the upper half of the accumulator.
  always_comb begin
    hi_idx    = AW'(WIDTH) + AW'(bit_cnt);
    op        = b_r[iter] & a_r[bit_cnt];
    fa_in     = acc[hi_idx];
    fa_sum    = fa_in ^ op ^ cy;
    fa_cy     = (fa_in & op) | (fa_in & cy) | (op & cy);
    acc_shift = {cy, acc[2*WIDTH-1:1]};
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = ADD;
      ADD:     if (bit_cnt == LAST) state_n = SHIFT;
      SHIFT:   state_n = (iter == LAST) ? IDLE : ADD;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      acc     <= '0;
      cy      <= 1'b0;
      bit_cnt <= '0;
      iter    <= '0;
      prod    <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            acc     <= '0;
            cy      <= 1'b0;
            bit_cnt <= '0;
            iter    <= '0;
          end
        end
        ADD: begin
          acc[hi_idx] <= fa_sum;
          cy          <= fa_cy;
          bit_cnt     <= (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
        end
        SHIFT: begin
          // The carry out of the row becomes the new MSB as the sum slides right.
          acc <= acc_shift;
          cy  <= 1'b0;
          if (iter == LAST) begin
            prod <= acc_shift;
            done <= 1'b1;
          end else begin
            iter <= iter + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mult_ctrl.sv
// Directed bench for serial_mult_ctrl at WIDTH=4: handshake timing, hold behaviour,
// ignored starts, mid-run reset and a back-to-back sweep of all operand pairs.
module tb_serial_mult_ctrl;

  localparam int W   = 4;
  localparam int LAT = W * (W + 1);

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_i, b_i;
  logic         busy, done;
  logic [2*W-1:0] prod;

  int checks   = 0;
  int failures = 0;

  serial_mult_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a_i),
    .b    (b_i),
    .busy (busy),
    .done (done),
    .prod (prod)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive start with operands for the edge E0; returns #1 after E0.
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv);
    a_i   = av;
    b_i   = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after E0 until done; every earlier cycle must show busy=1, done=0
  // and prod equal to hold. Returns #1 after the edge that raised done.
  task automatic wait_done(input logic [2*W-1:0] hold, output int lat, output int bad);
    lat = -1;
    bad = 0;
    for (int k = 1; k <= 3 * LAT; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        if (busy) bad++;
        break;
      end
      if (busy !== 1'b1 || prod !== hold) bad++;
    end
  endtask

  int lat, bad, extra;
  logic [2*W-1:0] prev;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a_i   = '0;
    b_i   = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_prod", 32'(prod), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 15*15
    launch(15, 15);
    wait_done(0, lat, bad);
    chk("max_latency", lat, LAT);
    chk("max_busy_window", bad, 0);
    chk("max_prod", 32'(prod), 225);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 0);
    repeat (9) @(posedge clk);
    #1;
    chk("max_prod_hold", 32'(prod), 225);
    chk("idle_busy", 32'(busy), 0);

    // zero operands
    launch(0, 13);
    wait_done(225, lat, bad);
    chk("zero_a_latency", lat, LAT);
    chk("zero_a_window", bad, 0);
    chk("zero_a_prod", 32'(prod), 0);
    @(negedge clk);
    launch(9, 0);
    wait_done(0, lat, bad);
    chk("zero_b_latency", lat, LAT);
    chk("zero_b_prod", 32'(prod), 0);

    // back-to-back start in the done cycle
    @(negedge clk);
    launch(9, 6);
    wait_done(0, lat, bad);
    chk("b2b_first_latency", lat, LAT);
    chk("b2b_first_prod", 32'(prod), 54);
    launch(7, 11);
    wait_done(54, lat, bad);
    chk("b2b_second_latency", lat, LAT);
    chk("b2b_hold_54", bad, 0);
    chk("b2b_second_prod", 32'(prod), 77);

    // start while busy is ignored; operand changes have no effect
    @(negedge clk);
    launch(5, 3);
    extra = 0;
    for (int k = 1; k <= LAT; k++) begin
      if (k == 7) begin
        a_i   = 15;
        b_i   = 15;
        start = 1'b1;
      end else begin
        a_i   = W'($urandom_range(0, 15));
        b_i   = W'($urandom_range(0, 15));
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (k < LAT && done) extra++;
    end
    chk("ignore_done_at_e20", 32'(done), 1);
    chk("ignore_prod", 32'(prod), 15);
    chk("ignore_early_done", extra, 0);
    start = 1'b0;
    extra = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) extra++;
    end
    chk("ignore_no_second_done", extra, 0);

    // mid-operation reset at E9
    @(negedge clk);
    launch(12, 10);
    repeat (9) @(posedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_prod", 32'(prod), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (done || busy || prod !== 0) extra++;
    end
    chk("abort_stays_idle", extra, 0);

    // exhaustive back-to-back sweep
    @(negedge clk);
    prev = '0;
    launch(0, 0);
    for (int i = 0; i < 256; i++) begin
      logic [W-1:0] av, bv;
      logic [2*W-1:0] exp_p;
      av    = W'(i / 16);
      bv    = W'(i % 16);
      exp_p = (2*W)'(i / 16) * (2*W)'(i % 16);
      wait_done(prev, lat, bad);
      if (lat < 0) begin
        chk("sweep_timeout", lat, LAT);
        break;
      end
      chk($sformatf("sweep_prod_%0dx%0d", av, bv), 32'(prod), 32'(exp_p));
      chk($sformatf("sweep_lat_%0dx%0d", av, bv), lat + bad, LAT);
      prev = exp_p;
      if (i < 255) launch(W'((i + 1) / 16), W'((i + 1) % 16));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
